// File: rtl/conv_module_with_adder.sv
// Streaming valid-region 2-D convolution: line buffers + shift window, one product stage, one adder-tree stage.
// Latency: dotproductReady pulses 2 rising edges after the edge that accepts a window's bottom-right pixel.
// Backpressure: isValid=0 freezes counters, buffers and kernel loading; issued pipeline stages still drain.
module conv_module_with_adder #(
    parameter int bitwidth    = 8,
    parameter int filterWidth = 3,
    parameter int imageWidth  = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [bitwidth-1:0] data_in,
    input  logic                isValid,
    input  logic [bitwidth-1:0] filter_in,
    output logic [31:0]         dotproduct,
    output logic                dotproductReady
);

    localparam int TAPS = filterWidth * filterWidth;
    localparam int CW   = $clog2(imageWidth);
    localparam int KW   = $clog2(TAPS + 1);
    localparam int PW   = 2 * bitwidth;
    localparam logic [CW-1:0] LAST = CW'(imageWidth - 1);
    localparam logic [CW-1:0] EDGE = CW'(filterWidth - 1);
    localparam logic [KW-1:0] NTAP = KW'(TAPS);

    logic [CW-1:0]       row;
    logic [CW-1:0]       col;
    logic [KW-1:0]       tap_cnt;
    logic [bitwidth-1:0] w       [TAPS];
    logic [bitwidth-1:0] lb      [filterWidth-1][imageWidth];
    logic [bitwidth-1:0] win     [filterWidth][filterWidth];
    logic [bitwidth-1:0] col_vec [filterWidth];
    logic                win_vld;
    logic [PW-1:0]       prod    [TAPS];
    logic                prod_vld;
    logic [31:0]         sum;

    // Column entering the window: buffered rows above, live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < filterWidth - 1; r++) begin
            col_vec[r] = lb[r][col];
        end
        col_vec[filterWidth-1] = data_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row     <= '0;
            col     <= '0;
            tap_cnt <= '0;
            for (int k = 0; k < TAPS; k++) begin
                w[k] <= '0;
            end
        end else if (isValid) begin
            if (tap_cnt < NTAP) begin
                w[tap_cnt] <= filter_in;
                tap_cnt    <= tap_cnt + 1'b1;
            end
            if (col == LAST) begin
                col <= '0;
                if (row == LAST) begin
                    row     <= '0;
                    tap_cnt <= '0;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_vld <= 1'b0;
            for (int r = 0; r < filterWidth - 1; r++) begin
                for (int c = 0; c < imageWidth; c++) begin
                    lb[r][c] <= '0;
                end
            end
            for (int r = 0; r < filterWidth; r++) begin
                for (int c = 0; c < filterWidth; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            win_vld <= isValid && (row >= EDGE) && (col >= EDGE);
            if (isValid) begin
                // Each line-buffer slot moves up one row; the bottom slot takes the live pixel.
                for (int r = 0; r < filterWidth - 1; r++) begin
                    lb[r][col] <= col_vec[r+1];
                end
                for (int r = 0; r < filterWidth; r++) begin
                    for (int c = 0; c < filterWidth - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                    win[r][filterWidth-1] <= col_vec[r];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_vld <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                prod[k] <= '0;
            end
        end else begin
            prod_vld <= win_vld;
            if (win_vld) begin
                for (int k = 0; k < TAPS; k++) begin
                    prod[k] <= PW'(win[k / filterWidth][k % filterWidth]) * PW'(w[k]);
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + 32'(prod[k]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dotproduct      <= '0;
            dotproductReady <= 1'b0;
        end else begin
            dotproductReady <= prod_vld;
            if (prod_vld) begin
                dotproduct <= sum;
            end
        end
    end

endmodule

// File: tb/tb_conv_module_with_adder.sv
// Frame-level bench: a reference correlation model fills a scoreboard at drive time; a monitor checks value and latency.
`timescale 1ns/1ps
module tb_conv_module_with_adder;
    localparam int IW = 11;
    localparam int FW = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = '0;
    logic [7:0]  filter_in = '0;
    logic        isValid = 1'b0;
    logic [31:0] dotproduct;
    logic        dotproductReady;

    conv_module_with_adder #(.bitwidth(8), .filterWidth(FW), .imageWidth(IW)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .isValid(isValid),
        .filter_in(filter_in), .dotproduct(dotproduct), .dotproductReady(dotproductReady)
    );

    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [31:0] val; int cyc; } exp_t;
    exp_t sb[$];

    int          case_strobes;
    logic [31:0] first_val;
    logic [31:0] last_val;

    typedef struct { int pm; int wm; int gap; int cnt; logic [31:0] first; logic [31:0] last; string name; } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'd1;
            1:       return 8'(r * IW + c);
            default: return 8'd255;
        endcase
    endfunction

    function automatic logic [7:0] wgt(input int mode, input int k);
        case (mode)
            0:       return 8'd1;
            1:       return (k == 4) ? 8'd1 : 8'd0;
            2:       return 8'd255;
            3:       return 8'd2;
            default: return 8'd3;
        endcase
    endfunction

    always @(negedge clock) begin
        if (!reset && dotproductReady) begin
            if (sb.size() == 0) begin
                check("spurious_strobe", 64'(dotproductReady), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dotproduct", 64'(dotproduct), 64'(e.val));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
            if (case_strobes == 0) first_val = dotproduct;
            last_val = dotproduct;
            case_strobes++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            isValid   = 1'b0;
            data_in   = 8'($urandom);
            filter_in = 8'($urandom);
        end
    endtask

    task automatic run_frame(input int pm, input int wm, input int gap, input int nbeats);
        logic [7:0] img [IW][IW];
        for (int r = 0; r < IW; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = pix(pm, r, c);
        for (int b = 0; b < nbeats; b++) begin
            int r;
            int c;
            r = b / IW;
            c = b % IW;
            if (gap > 0 && $urandom_range(99) < gap) idle($urandom_range(1, 3));
            @(negedge clock);
            isValid   = 1'b1;
            data_in   = img[r][c];
            filter_in = (b < FW * FW) ? wgt(wm, b) : 8'($urandom);
            if (r >= FW - 1 && c >= FW - 1) begin
                exp_t e;
                logic [31:0] s;
                s = '0;
                for (int r2 = 0; r2 < FW; r2++)
                    for (int c2 = 0; c2 < FW; c2++)
                        s = s + 32'(img[r-2+r2][c-2+c2]) * 32'(wgt(wm, r2 * FW + c2));
                e.val = s;
                e.cyc = cyc + 3;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 0, 0,  81, 32'd9,      32'd9,      "ones"};
        tbl[1] = '{1, 1, 0,  81, 32'd12,     32'd108,    "centre_ramp"};
        tbl[2] = '{2, 2, 0,  81, 32'd585225, 32'd585225, "max"};
        tbl[3] = '{1, 1, 40, 81, 32'd12,     32'd108,    "centre_ramp_gaps"};
        tbl[4] = '{0, 3, 0,  81, 32'd18,     32'd18,     "weights_two"};

        repeat (3) @(negedge clock);
        check("reset_dotproduct", 64'(dotproduct), 64'd0);
        check("reset_ready", 64'(dotproductReady), 64'd0);
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < 5; i++) begin
            case_strobes = 0;
            run_frame(tbl[i].pm, tbl[i].wm, tbl[i].gap, IW * IW);
            idle(4);
            check({tbl[i].name, "_count"}, 64'(case_strobes), 64'(tbl[i].cnt));
            check({tbl[i].name, "_first"}, 64'(first_val), 64'(tbl[i].first));
            check({tbl[i].name, "_last"}, 64'(last_val), 64'(tbl[i].last));
        end

        // Reset after beat 60 of a frame: outputs clear at once, in-flight results vanish.
        run_frame(0, 0, 0, 61);
        @(negedge clock);
        isValid = 1'b0;
        check("pre_reset_dotproduct", 64'(dotproduct), 64'd9);
        reset = 1'b1;
        #1;
        check("midreset_dotproduct", 64'(dotproduct), 64'd0);
        check("midreset_ready", 64'(dotproductReady), 64'd0);
        sb.delete();
        idle(2);
        reset = 1'b0;
        case_strobes = 0;
        idle(4);
        check("post_reset_quiet", 64'(case_strobes), 64'd0);
        run_frame(0, 4, 0, IW * IW);
        idle(4);
        check("restart_count", 64'(case_strobes), 64'd81);
        check("restart_first", 64'(first_val), 64'd27);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
